// File: rtl/prbs7_checker.sv
// Receive-side PRBS7 (x^7+x^6+1, LSB-first) checker: self-synchronises a local
// reference, declares lock, then accumulates saturating error statistics.
module prbs7_checker #(
    parameter int unsigned WORDWIDTH    = 32,
    parameter int unsigned LOCK_COUNT   = 16,
    parameter int unsigned UNLOCK_COUNT = 4,
    parameter int unsigned UNLOCK_BITS  = 8,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clear_cnt,
    input  logic [WORDWIDTH-1:0] din,
    output logic                 locked,
    output logic                 err_word,
    output logic [5:0]           err_bits,
    output logic [CNT_WIDTH-1:0] bit_err_count,
    output logic [CNT_WIDTH-1:0] err_word_count,
    output logic [CNT_WIDTH-1:0] relock_count
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam int unsigned SUM_W  = ((CNT_WIDTH > 6) ? CNT_WIDTH : 6) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [6:0]           lfsr_q, lfsr_d;
    logic [GOOD_W-1:0]    good_q, good_d;
    logic [BAD_W-1:0]     bad_q, bad_d;
    logic                 locked_d, err_word_d;
    logic [5:0]           err_bits_d;
    logic [CNT_WIDTH-1:0] bit_cnt_d, word_cnt_d, relock_d;

    logic [WORDWIDTH-1:0] pred_c;
    logic [WORDWIDTH-1:0] err_vec_c;
    logic [5:0]           pop_c;
    logic [6:0]           seed_c;
    logic [6:0]           pred_state_c;
    logic [GOOD_W-1:0]    good_inc_c;
    logic [BAD_W-1:0]     bad_inc_c;

    // Predicted word from the last 7 sequence bits (lfsr[6] is the newest bit).
    function automatic logic [WORDWIDTH-1:0] prbs_word(input logic [6:0] st);
        logic [WORDWIDTH+6:0] ext;
        ext      = '0;
        ext[6:0] = st;
        for (int i = 0; i < int'(WORDWIDTH); i++) begin
            ext[i+7] = ext[i] ^ ext[i+1];
        end
        return ext[WORDWIDTH+6:7];
    endfunction

    function automatic logic [5:0] popcount(input logic [WORDWIDTH-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < int'(WORDWIDTH); i++) begin
            c = c + 6'(v[i]);
        end
        return c;
    endfunction

    // Saturating accumulate; the sum is widened so a narrow counter cannot wrap.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [5:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > CNT_MAX) ? {CNT_WIDTH{1'b1}} : CNT_WIDTH'(s);
    endfunction

    always_comb begin
        pred_c       = prbs_word(lfsr_q);
        err_vec_c    = din ^ pred_c;
        pop_c        = popcount(err_vec_c);
        seed_c       = din[WORDWIDTH-1 -: 7];
        pred_state_c = pred_c[WORDWIDTH-1 -: 7];
        good_inc_c   = good_q + GOOD_W'(1);
        bad_inc_c    = bad_q + BAD_W'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        good_d     = good_q;
        bad_d      = bad_q;
        locked_d   = locked;
        err_word_d = 1'b0;
        err_bits_d = '0;
        bit_cnt_d  = bit_err_count;
        word_cnt_d = err_word_count;
        relock_d   = relock_count;

        if (en) begin
            case (state_q)
                HUNT: begin
                    lfsr_d = seed_c;
                    good_d = '0;
                    if (seed_c != 7'd0) begin
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (din == pred_c) begin
                        lfsr_d = pred_state_c;
                        if (good_inc_c == GOOD_W'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            good_d   = '0;
                            bad_d    = '0;
                        end else begin
                            good_d = good_inc_c;
                        end
                    end else begin
                        lfsr_d  = seed_c;
                        good_d  = '0;
                        state_d = (seed_c != 7'd0) ? VERIFY : HUNT;
                    end
                end
                LOCKED: begin
                    lfsr_d     = pred_state_c;
                    err_bits_d = pop_c;
                    err_word_d = |err_vec_c;
                    bit_cnt_d  = sat_add(bit_err_count, pop_c);
                    word_cnt_d = sat_add(err_word_count, 6'(|err_vec_c));
                    if (pop_c >= 6'(UNLOCK_BITS)) begin
                        if (bad_inc_c == BAD_W'(UNLOCK_COUNT)) begin
                            state_d  = HUNT;
                            locked_d = 1'b0;
                            bad_d    = '0;
                            relock_d = sat_add(relock_count, 6'd1);
                        end else begin
                            bad_d = bad_inc_c;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: begin
                    state_d  = HUNT;
                    locked_d = 1'b0;
                end
            endcase
        end

        if (clear_cnt) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            relock_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= HUNT;
            lfsr_q         <= '0;
            good_q         <= '0;
            bad_q          <= '0;
            locked         <= 1'b0;
            err_word       <= 1'b0;
            err_bits       <= '0;
            bit_err_count  <= '0;
            err_word_count <= '0;
            relock_count   <= '0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            good_q         <= good_d;
            bad_q          <= bad_d;
            locked         <= locked_d;
            err_word       <= err_word_d;
            err_bits       <= err_bits_d;
            bit_err_count  <= bit_cnt_d;
            err_word_count <= word_cnt_d;
            relock_count   <= relock_d;
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: a serial reference generator drives both a
// 32-bit-counter and a 4-bit-counter instance with identical stimulus.
module tb_prbs7_checker;

    logic        clk;
    logic        reset;
    logic        en;
    logic        clear_cnt;
    logic [31:0] din;

    logic        locked, err_word;
    logic [5:0]  err_bits;
    logic [31:0] bit_err_count, err_word_count, relock_count;

    logic        locked4, err_word4;
    logic [5:0]  err_bits4;
    logic [3:0]  bit_err_count4, err_word_count4, relock_count4;

    int          errors = 0;
    int          checks = 0;
    logic [6:0]  g;
    logic [31:0] w;

    prbs7_checker u_dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .clear_cnt      (clear_cnt),
        .din            (din),
        .locked         (locked),
        .err_word       (err_word),
        .err_bits       (err_bits),
        .bit_err_count  (bit_err_count),
        .err_word_count (err_word_count),
        .relock_count   (relock_count)
    );

    prbs7_checker #(.CNT_WIDTH(4)) u_dut4 (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .clear_cnt      (clear_cnt),
        .din            (din),
        .locked         (locked4),
        .err_word       (err_word4),
        .err_bits       (err_bits4),
        .bit_err_count  (bit_err_count4),
        .err_word_count (err_word_count4),
        .relock_count   (relock_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bit-serial TX-style generator: new bit = s[n-7]^s[n-6], earliest bit in din[0].
    task automatic next_word(output logic [31:0] wd);
        logic b;
        for (int i = 0; i < 32; i++) begin
            b     = g[0] ^ g[1];
            wd[i] = b;
            g     = {b, g[6:1]};
        end
    endtask

    task automatic step(input logic [31:0] d, input logic e, input logic c);
        din       = d;
        en        = e;
        clear_cnt = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; clear_cnt = 1'b0; din = '0; g = 7'h7F;
        #2 reset = 1'b0;
        #2;
        chk("reset_locked", 32'(locked), 0);
        chk("reset_err_word", 32'(err_word), 0);
        chk("reset_err_bits", 32'(err_bits), 0);
        chk("reset_bit_cnt", bit_err_count, 0);
        chk("reset_relock", relock_count, 0);
        @(negedge clk);
        reset = 1'b1;

        // All-zero input never seeds the reference.
        repeat (20) step(32'h0, 1'b1, 1'b0);
        chk("zero_locked", 32'(locked), 0);
        chk("zero_bit_cnt", bit_err_count, 0);
        chk("zero_word_cnt", err_word_count, 0);

        // Clean acquisition: one HUNT word plus LOCK_COUNT verified words.
        for (int k = 1; k <= 16; k++) begin
            next_word(w);
            step(w, 1'b1, 1'b0);
        end
        chk("acq_locked_16", 32'(locked), 0);
        next_word(w);
        step(w, 1'b1, 1'b0);
        chk("acq_locked_17", 32'(locked), 1);
        for (int k = 0; k < 1000; k++) begin
            next_word(w);
            step(w, 1'b1, 1'b0);
        end
        chk("clean_locked", 32'(locked), 1);
        chk("clean_bit_cnt", bit_err_count, 0);
        chk("clean_word_cnt", err_word_count, 0);
        chk("clean_relock", relock_count, 0);

        // Single flipped bit: no error multiplication.
        next_word(w);
        step(w ^ 32'h20, 1'b1, 1'b0);
        chk("flip_err_word", 32'(err_word), 1);
        chk("flip_err_bits", 32'(err_bits), 1);
        chk("flip_bit_cnt", bit_err_count, 1);
        chk("flip_word_cnt", err_word_count, 1);
        next_word(w);
        step(w, 1'b1, 1'b0);
        chk("flip_after_bits", 32'(err_bits), 0);
        chk("flip_after_word", 32'(err_word), 0);
        chk("flip_after_locked", 32'(locked), 1);
        chk("flip_after_bit_cnt", bit_err_count, 1);

        // Sub-threshold bursts separated by a clean word.
        next_word(w);
        step(w, 1'b1, 1'b1);
        chk("sub_cleared", bit_err_count, 0);
        for (int k = 0; k < 7; k++) begin
            next_word(w);
            step((k == 3) ? w : (w ^ 32'hFF), 1'b1, 1'b0);
        end
        chk("sub_err_bits", 32'(err_bits), 8);
        chk("sub_locked", 32'(locked), 1);
        chk("sub_relock", relock_count, 0);
        chk("sub_bit_cnt", bit_err_count, 48);
        chk("sub_word_cnt", err_word_count, 6);

        // Clear wins over same-cycle accumulation but leaves the flags alone.
        next_word(w);
        step(w ^ 32'h1, 1'b1, 1'b1);
        chk("clr_bit_cnt", bit_err_count, 0);
        chk("clr_word_cnt", err_word_count, 0);
        chk("clr_err_word", 32'(err_word), 1);
        chk("clr_err_bits", 32'(err_bits), 1);
        chk("clr_locked", 32'(locked), 1);

        // Idle with en low: everything holds, flags drop.
        next_word(w);
        step(w ^ 32'h100, 1'b1, 1'b0);
        chk("idle_pre_bit_cnt", bit_err_count, 1);
        repeat (10) step(32'hDEADBEEF, 1'b0, 1'b0);
        chk("idle_bit_cnt", bit_err_count, 1);
        chk("idle_word_cnt", err_word_count, 1);
        chk("idle_err_word", 32'(err_word), 0);
        chk("idle_err_bits", 32'(err_bits), 0);
        chk("idle_locked", 32'(locked), 1);
        next_word(w);
        step(w, 1'b1, 1'b0);
        chk("resume_locked", 32'(locked), 1);
        chk("resume_err_bits", 32'(err_bits), 0);
        chk("resume_bit_cnt", bit_err_count, 1);

        // Saturation of the 4-bit counters.
        next_word(w);
        step(w, 1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            next_word(w);
            step(w ^ (32'h1 << k), 1'b1, 1'b0);
        end
        chk("sat_bit_cnt32", bit_err_count, 20);
        chk("sat_bit_cnt4", 32'(bit_err_count4), 15);
        chk("sat_word_cnt4", 32'(err_word_count4), 15);
        chk("sat_locked4", 32'(locked4), 1);

        // Four fully inverted words force a relock.
        next_word(w);
        step(w, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            next_word(w);
            step(~w, 1'b1, 1'b0);
            chk("loss_err_bits", 32'(err_bits), 32);
            chk("loss_locked", 32'(locked), (k < 3) ? 32'd1 : 32'd0);
        end
        chk("loss_relock", relock_count, 1);
        chk("loss_bit_cnt", bit_err_count, 128);
        chk("loss_word_cnt", err_word_count, 4);
        chk("loss_relock4", 32'(relock_count4), 1);
        chk("loss_bit_cnt4", 32'(bit_err_count4), 15);
        for (int k = 1; k <= 16; k++) begin
            next_word(w);
            step(w, 1'b1, 1'b0);
        end
        chk("relock_16", 32'(locked), 0);
        next_word(w);
        step(w, 1'b1, 1'b0);
        chk("relock_17", 32'(locked), 1);
        chk("relock_cnt_hold", relock_count, 1);

        // Asynchronous reset mid-LOCKED, sampled before the next edge.
        #2 reset = 1'b0;
        #1;
        chk("areset_locked", 32'(locked), 0);
        chk("areset_err_word", 32'(err_word), 0);
        chk("areset_err_bits", 32'(err_bits), 0);
        chk("areset_bit_cnt", bit_err_count, 0);
        chk("areset_word_cnt", err_word_count, 0);
        chk("areset_relock", relock_count, 0);
        chk("areset_relock4", 32'(relock_count4), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
